// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared definitions for the keypad scanner: FSM encoding, key indices,
// the physical (row,col) to key-bit map and a one-hot helper.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 3;
  localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;

  localparam int unsigned KEY_STAR = 10;
  localparam int unsigned KEY_HASH = 11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_DEBOUNCE = DEBOUNCE;
  localparam logic [1:0] S_EMIT     = EMIT;
  localparam logic [1:0] S_RELEASE  = RELEASE;

  // Entry [row*3 + col] is the key bit driven by that switch position.
  localparam logic [NUM_KEYS-1:0][3:0] KEY_MAP = {
    4'(KEY_HASH), 4'd0, 4'(KEY_STAR),
    4'd9,         4'd8, 4'd7,
    4'd6,         4'd5, 4'd4,
    4'd3,         4'd2, 4'd1
  };

  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// Key press interface towards the consumer: one-hot press pulse plus busy.
interface keypad_matrix_scanner_if;
  import keypad_pkg::*;

  logic [NUM_KEYS-1:0] key;
  logic                busy;

  modport master (output key, output busy);
  modport slave  (input  key, input  busy);
endinterface

// File: rtl/keypad_matrix_scanner_sync_2ff.sv
// Two-flop synchronizer; resets to all ones so idle pulled-up inputs read inactive.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x3 keypad scanner: row drive, column sampling, frame-level debounce FSM and
// a fixed-length one-hot press pulse per accepted key.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 4,
  parameter int unsigned PULSE_LEN       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_COLS-1:0]  col_n,
  output logic [NUM_ROWS-1:0]  row_n,
  keypad_matrix_scanner_if.master key_if
);

  localparam int unsigned SLOT_W  = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int unsigned PULSE_W = $clog2(PULSE_LEN + 1);

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_DONE   = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_LEN - 1);

  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [1:0]          row_q, row_d;
  logic [NUM_KEYS-1:0] snap_q, snap_d;
  logic [1:0]          state_q, state_d;
  logic [NUM_KEYS-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PULSE_W-1:0]  pulse_q, pulse_d;
  logic [NUM_KEYS-1:0] key_q, key_d;
  logic                busy_q, busy_d;

  logic [NUM_COLS-1:0] col_sync;
  logic [NUM_KEYS-1:0] pos_hit;
  logic [NUM_KEYS-1:0] row_mask;
  logic [NUM_KEYS-1:0] frame_bits;
  logic                last_slot;
  logic                frame_end;

  sync_2ff #(.WIDTH(NUM_COLS)) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d   (col_n),
    .q   (col_sync)
  );

  // Each switch position only contributes while its own row is driven; the
  // map is a permutation, so every row_mask bit has exactly one driver.
  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_pos
    assign pos_hit[gi] = (row_q == 2'(gi / NUM_COLS)) && !col_sync[gi % NUM_COLS];
    assign row_mask[KEY_MAP[gi]] = pos_hit[gi];
  end

  assign last_slot  = (slot_q == SLOT_LAST);
  assign frame_end  = last_slot && (row_q == 2'd3);
  assign frame_bits = snap_q | row_mask;

  always_comb begin
    slot_d = last_slot ? '0 : slot_q + 1'b1;
    row_d  = last_slot ? row_q + 2'd1 : row_q;
    snap_d = snap_q;
    if (last_slot) begin
      snap_d = frame_end ? '0 : frame_bits;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    key_d   = key_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (frame_end && is_onehot(frame_bits)) begin
          cand_d  = frame_bits;
          cnt_d   = CNT_ONE;
          busy_d  = 1'b1;
          if (CNT_DONE <= CNT_ONE) begin
            state_d = S_EMIT;
            key_d   = frame_bits;
            pulse_d = '0;
          end else begin
            state_d = S_DEBOUNCE;
          end
        end
      end
      S_DEBOUNCE: begin
        if (frame_end) begin
          if (frame_bits == cand_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q + 1'b1 == CNT_DONE) begin
              state_d = S_EMIT;
              key_d   = cand_q;
              pulse_d = '0;
            end
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      // Pulse timing is counted in clock cycles; frame ends are ignored here.
      S_EMIT: begin
        if (pulse_q == PULSE_LAST) begin
          key_d   = '0;
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else begin
          pulse_d = pulse_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (frame_end) begin
          if (frame_bits == '0) begin
            if (cnt_q + 1'b1 == CNT_DONE) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        key_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q  <= '0;
      row_q   <= '0;
      snap_q  <= '0;
      state_q <= S_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      pulse_q <= '0;
      key_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      row_q   <= row_d;
      snap_q  <= snap_d;
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
    end
  end

  assign row_n       = ~(4'b0001 << row_q);
  assign key_if.key  = key_q;
  assign key_if.busy = busy_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboarded bench for keypad_matrix_scanner with a behavioural 4x3 keypad model.
module tb_keypad_matrix_scanner;

  localparam int SD    = 4;
  localparam int DF    = 2;
  localparam int PL    = 2;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  col_n;
  logic [3:0]  row_n;
  logic [11:0] pressed = '0;

  keypad_matrix_scanner_if kif ();

  keypad_matrix_scanner #(
    .SCAN_DIV        (SD),
    .DEBOUNCE_FRAMES (DF),
    .PULSE_LEN       (PL)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .col_n  (col_n),
    .row_n  (row_n),
    .key_if (kif)
  );

  always #5 clk = ~clk;

  // A pressed switch shorts its column to its row while that row is driven low.
  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3 + c] && !row_n[r]) col_n[c] = 1'b0;
  end

  int          vectors     = 0;
  int          miscompares = 0;
  logic [11:0] exp_q[$];
  logic [11:0] prev_key = '0;
  int          run      = 0;

  // Output monitor: pops the scoreboard on every rising pulse, checks pulse shape.
  always begin
    logic [11:0] e;
    @(posedge clk);
    #2;
    if (rst) begin
      prev_key = '0;
      run      = 0;
    end else begin
      if (kif.key != 12'h000) begin
        if (prev_key == 12'h000) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_pulse: key=%h, required no pulse", kif.key);
          end else begin
            e = exp_q.pop_front();
            if (kif.key !== e) begin
              miscompares++;
              $display("FAIL pulse_value: key=%h, required %h", kif.key, e);
            end else begin
              $display("pulse key=%h at %0t", kif.key, $time);
            end
          end
        end
        vectors++;
        if ($countones(kif.key) != 1 || kif.busy !== 1'b1 ||
            (prev_key != 12'h000 && kif.key !== prev_key)) begin
          miscompares++;
          $display("FAIL pulse_shape: key=%h busy=%b prev=%h, required stable one-hot with busy=1",
                   kif.key, kif.busy, prev_key);
        end
        run++;
      end else if (prev_key != 12'h000) begin
        vectors++;
        if (run != PL) begin
          miscompares++;
          $display("FAIL pulse_len: %0d cycles, required %0d", run, PL);
        end
        run = 0;
      end
      prev_key = kif.key;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_key(input int r, input int c, input bit v);
    pressed[r*3 + c] = v;
  endtask

  task automatic wait_frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  // Returns at the first negedge of a new frame (row 0 has just been driven).
  task automatic align_frame();
    logic [3:0] last;
    bit         found;
    last  = row_n;
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if (row_n == 4'b1110 && last == 4'b0111) found = 1;
      last = row_n;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL align_frame: row_n=%b, required 1110 after 0111", row_n);
    end
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 6 * FRAME && !done; i++) begin
      if (exp_q.size() == 0 && prev_key == 12'h000) done = 1;
      else @(negedge clk);
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL drain_%s: %0d pulses outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 6 * FRAME && kif.busy !== 1'b0; i++) @(negedge clk);
    vectors++;
    if (kif.busy !== 1'b0 || kif.key !== 12'h000) begin
      miscompares++;
      $display("FAIL idle_%s: busy=%b key=%h, required busy=0 key=000", name, kif.busy, kif.key);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (row_n !== 4'b1110 || kif.key !== 12'h000 || kif.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: row_n=%b key=%h busy=%b, required 1110 000 0",
               row_n, kif.key, kif.busy);
    end
    rst = 1'b0;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      vectors++;
      if (row_n !== exp_row) begin
        miscompares++;
        $display("FAIL row_rotate[%0d]: row_n=%b, required %b", k, row_n, exp_row);
      end
    end
  endtask

  task automatic test_single_press();
    int lat;
    align_frame();
    exp_q.push_back(12'h004);
    set_key(0, 1, 1);
    lat = 0;
    for (int i = 0; i < 3 * FRAME && kif.key == 12'h000; i++) begin
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (kif.key == 12'h000 || lat < (DF - 1) * FRAME || lat > DF * FRAME + 3) begin
      miscompares++;
      $display("FAIL press_latency: %0d cycles, required %0d..%0d",
               lat, (DF - 1) * FRAME, DF * FRAME + 3);
    end
    wait_drain("single");
    wait_frames(9);
    set_key(0, 1, 0);
    wait_idle("single");
  endtask

  task automatic test_sequence();
    int          rr [3] = '{3, 3, 3};
    int          cc [3] = '{0, 2, 1};
    logic [11:0] ee [3] = '{12'h400, 12'h800, 12'h001};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ee[i]);
      set_key(rr[i], cc[i], 1);
      wait_drain("sequence");
      wait_frames(1);
      set_key(rr[i], cc[i], 0);
      wait_idle("sequence");
    end
  endtask

  task automatic test_bounce();
    repeat (5) begin
      set_key(1, 1, 1);
      wait_frames(1);
      set_key(1, 1, 0);
      wait_frames(1);
    end
    exp_q.push_back(12'h020);
    set_key(1, 1, 1);
    wait_frames(3);
    wait_drain("bounce");
    set_key(1, 1, 0);
    wait_idle("bounce");
  endtask

  task automatic test_two_keys();
    bit busy_seen;
    align_frame();
    set_key(0, 0, 1);
    set_key(2, 2, 1);
    busy_seen = 0;
    repeat (4 * FRAME) begin
      @(negedge clk);
      if (kif.busy) busy_seen = 1;
    end
    vectors++;
    if (busy_seen) begin
      miscompares++;
      $display("FAIL two_keys_busy: busy went 1, required 0");
    end
    set_key(0, 0, 0);
    set_key(2, 2, 0);
    wait_frames(2);
    exp_q.push_back(12'h002);
    set_key(0, 0, 1);
    wait_drain("first_of_two");
    set_key(2, 2, 1);
    wait_frames(3);
    set_key(0, 0, 0);
    wait_frames(2);
    vectors++;
    if (kif.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL held_second_busy: busy=%b, required 1", kif.busy);
    end
    set_key(2, 2, 0);
    wait_idle("two_keys");
  endtask

  task automatic test_reset_mid_pulse();
    bit seen;
    exp_q.push_back(12'h010);
    set_key(1, 0, 1);
    seen = 0;
    for (int i = 0; i < 4 * FRAME && !seen; i++) begin
      @(negedge clk);
      if (kif.key == 12'h010) seen = 1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL reset_mid_start: key=%h, required 010", kif.key);
      exp_q.delete();
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (kif.key !== 12'h000 || kif.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_abort: key=%h busy=%b, required 000 0", kif.key, kif.busy);
    end
    rst = 1'b0;
    exp_q.push_back(12'h010);
    wait_drain("after_reset");
    set_key(1, 0, 0);
    wait_idle("after_reset");
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_sequence();
    test_bounce();
    test_two_keys();
    test_reset_mid_pulse();
    wait_frames(2);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL final_queue: %0d outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
Drives a physical 4x3 matrix keypad, debounces it and produces the one-hot key[11:0] press pulses consumed by safe_top. It is the source end of the key interface: one debounced press yields exactly one PULSE_LEN-cycle one-hot pulse, then key returns to 0. It sits between the board keypad pins and safe_top, on the same clock.

Parameters:
SCAN_DIV, 1000, clock cycles each row stays driven; must be >= 4 for synchronizer settle
DEBOUNCE_FRAMES, 4, consecutive identical full-scan frames required to accept a press or a release
PULSE_LEN, 2, cycles the one-hot key output is held high per accepted press

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
col_n  input  3  keypad columns, active-low, externally pulled up, asynchronous to clk
row_n  output  4  keypad row drive, active-low, exactly one row low at a time
key  output  12  one-hot press pulse to safe_top; bit d = digit d, bit 10 = '*', bit 11 = '#'
busy  output  1  high from the first debounce frame until release is accepted

Behaviour:
- Reset: row index 0, row_n=4'b1110, key=0, busy=0, synchronizer flops=3'b111, frame snapshot=0, FSM=IDLE, counters=0. rst asserted mid-operation aborts everything, including a key pulse in progress; key is 0 on the next edge.
- col_n passes a 2-flop synchronizer before use.
- Scan: slot counter counts 0..SCAN_DIV-1 per row. Columns are sampled on the last slot cycle, then the row advances 0->1->2->3->0. row_n = ~(1<<row).
- Key map (row,col): r0: 1,2,3; r1: 4,5,6; r2: 7,8,9; r3: 10(*),0,11(#). A column read low while row r is driven sets the mapped bit of a 12-bit frame snapshot.
- Frame: 4*SCAN_DIV cycles. The snapshot is evaluated on the cycle row 3 is sampled, then cleared for the next frame.
- FSM, evaluated once per frame end:
  - IDLE: snapshot one-hot -> cand=snapshot, cnt=1, go to DEBOUNCE, busy=1. Zero or multiple bits -> stay IDLE.
  - DEBOUNCE: snapshot==cand -> cnt++. Reaching DEBOUNCE_FRAMES -> EMIT. Mismatch, including an added second key -> IDLE, busy=0.
  - EMIT (cycle-timed, not frame-timed): key=cand for exactly PULSE_LEN cycles starting the cycle after acceptance, then key=0 and go to RELEASE with cnt=0.
  - RELEASE: snapshot==0 -> cnt++. Nonzero snapshot -> cnt=0. cnt==DEBOUNCE_FRAMES -> IDLE, busy=0.
- Holding a key produces one pulse only; no auto-repeat. A second key pressed while the first is held is ignored until full release.
- Scanning continues in every state.
- Latency from a stable press to the key rising edge is between (DEBOUNCE_FRAMES-1) and DEBOUNCE_FRAMES frames, plus 3 cycles (sync plus register).
- key is never multi-hot, and is 0 outside EMIT.

Decomposition:
- Shared package keypad_pkg: state enum (IDLE, DEBOUNCE, EMIT, RELEASE); KEY_STAR=10, KEY_HASH=11; 4x3 row/col-to-index map constant; a one-hot check function.
- One sub-module: sync_2ff (parameterized width, reset value 1s), instantiated for col_n.

Test Plan:
Bench parameters SCAN_DIV=4, DEBOUNCE_FRAMES=2, PULSE_LEN=2. The keypad model pulls col_n[c] low while row_n[r]==0 and (r,c) is pressed.
- Reset check: rst high 2 cycles, then low -> row_n=1110, key=0, busy=0. Row_n rotates 1110,1101,1011,0111 every 4 cycles.
- Press (0,1) steadily -> exactly one pulse key=12'h004 (digit 2) lasting 2 cycles, within 2 frames + 3 cycles. Key held 10 frames -> no second pulse.
- Press (3,0) then release; press (3,2) then release; press (3,1) -> pulses 12'h400, 12'h800, 12'h001 in order, busy low between presses.
- Bounce: (1,1) pressed for 1 frame, released 1 frame, repeated 5 times -> no pulse. Then held 3 frames -> one pulse 12'h020.
- Two keys (0,0) and (2,2) pressed together -> no pulse, busy stays 0. While (0,0) is held after its pulse, press (2,2) -> no second pulse until both are released for 2 frames.
- rst asserted during the EMIT cycle of key 12'h010 -> key=0 on the next edge, FSM=IDLE. With the key still held after reset, a fresh debounce yields one new pulse.
